imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory. It receives a program image as a byte stream from a UART RX or debug port, assembles the bytes into 32-bit little-endian words, and issues single-cycle word writes into the instruction memory write port.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image has been written.
- Sits between the host byte source and the imem write port, beside the core.

Parameters:
- mem_size, 17, number of 32-bit words in the instruction memory; images longer than this are rejected.
- base_addr, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the write (word aligned).
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  hold the core in reset / stall fetch.
- busy  output  1  load in progress.
- done  output  1  image loaded and verified (level).
- error  output  1  load failed (level).
- words_loaded  output  16  words written in the current/last load.

Behaviour:
- Reset values:
  - in_ready=0, mem_we=0, mem_addr=base_addr, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - State=IDLE, checksum=0.
- Frame format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, least significant byte of each word first.
  - CHK: 8-bit sum mod 256 of the payload bytes only.
- A byte is accepted when in_valid && in_ready. in_ready=1 exactly in states LEN0, LEN1, DATA and CHK.
- States and transitions:
  - IDLE: on start go to LEN0. Clear done, error, words_loaded and checksum; set busy=1 and cpu_hold=1.
  - LEN0: accept a byte, latch it as the low length byte, go to LEN1.
  - LEN1: accept a byte, giving N.
    - N > mem_size: go to ERR.
    - N == 0: go to CHK.
    - Otherwise: go to DATA.
  - DATA: shift accepted bytes into the word register and add each to the checksum.
    - On the 4th byte of a word, the following cycle drives mem_we=1, mem_wdata=assembled word, mem_addr=base_addr+4*index. words_loaded increments in the same cycle.
    - After word N-1 is accepted, go to CHK.
    - in_ready stays 1 during the write cycle, because the write register is separate from the assembly register.
  - CHK: accept a byte. If it equals the running sum, go to DONE; otherwise go to ERR.
  - DONE: done=1, busy=0, cpu_hold=0. start re-enters the IDLE actions (reload) and reasserts cpu_hold in the next cycle.
  - ERR: error=1, busy=0, cpu_hold stays 1. start retries the load.
- start is ignored in LEN0, LEN1, DATA and CHK.
- Backpressure: in_valid=0 gaps of any length are tolerated; state and partial words are held.
- Address arithmetic is 32-bit and wraps modulo 2^32. The index never exceeds mem_size-1 because of the length check.
- If rst asserts mid-load, all outputs return to their reset values immediately. A partially assembled word is discarded and never written. Words already written stay in memory.
- Latency: last payload byte to mem_we is 1 cycle. CHK byte accepted to done/cpu_hold=0 is 1 cycle.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR);
  - localparam WORD_BYTES=4 and LEN_W=16;
  - the checksum width constant.
- Sub-module word_assembler holds the byte shift register, the 2-bit byte counter and the word_ready pulse. The top level holds the FSM, checksum, address counter and write register.

Test Plan:
- Two-word load: start, then bytes 02 00, 93 00 50 00, 13 01 A0 00, 97 -> mem_we pulses twice: addr 0x0 data 0x00500093, then addr 0x4 data 0x00A00113. done=1, cpu_hold=0, words_loaded=2.
- Bad checksum: same stream with CHK=0x98 -> both writes still occur; error=1, done=0, cpu_hold=1.
- Oversize: length bytes 12 00 (N=18 > 17) -> ERR right after LEN1, no mem_we, in_ready=0.
- Zero length: bytes 00 00 00 -> no writes, done=1, words_loaded=0. Bytes 00 00 01 -> error=1.
- Backpressure and reset: one-word load with a random 0–5 cycle in_valid gap between each byte -> same write as without gaps. Repeat with rst pulsed after the 3rd payload byte -> no mem_we, cpu_hold=1, state IDLE; a fresh load then succeeds.
- Reload: after done, start with one word 0xDEADBEEF (bytes 01 00 EF BE AD DE, CHK 0x38) -> cpu_hold rises the cycle after start, write at 0x0, done again.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader:
//             FSM state encoding, frame field widths and checksum width.
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int WORD_BYTES = 4;   // bytes per instruction word
    localparam int LEN_W      = 16;  // width of the frame word-count field
    localparam int CHK_W      = 8;   // width of the running payload checksum

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Collects payload bytes (least significant first) into 32-bit
//             words. The completed word is presented combinationally together
//             with word_ready on the cycle the 4th byte is accepted, so the
//             caller can register it with one cycle of latency.
//  Ports    : clk, rst        - clock, async active-high reset
//             clear           - discard any partial word (new load)
//             byte_valid      - byte_data is accepted this cycle
//             byte_data [7:0] - payload byte
//             word     [31:0] - assembled word (valid when word_ready)
//             word_ready      - single-cycle pulse on the 4th byte of a word
//  Revision : 1.0 - initial release
// ============================================================================
import loader_pkg::*;

module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input when the word completes.
    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;

    assign word       = {byte_data, r_shift};
    assign word_ready = byte_valid && (r_byte_cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (clear) begin
            r_byte_cnt <= '0;
        end else if (byte_valid) begin
            r_shift    <= {byte_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a length/payload/checksum framed program image as a
//             byte stream, writes it into instruction memory one 32-bit word
//             at a time and holds the core in reset until a complete,
//             checksum-verified image has been written.
//  Ports    : clk, rst             - clock, async active-high reset
//             start                - begin a load (IDLE/DONE/ERR only)
//             in_valid/in_data     - byte stream in
//             in_ready             - a byte can be accepted this cycle
//             mem_we/addr/wdata    - instruction memory write port
//             cpu_hold             - keep the core in reset
//             busy/done/error      - load status
//             words_loaded [15:0]  - words written in current/last load
//  Revision : 1.0 - initial release
// ============================================================================
import loader_pkg::*;

module imem_loader #(
    parameter int          MEM_SIZE  = 17,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_len_lo;
    logic [LEN_W-1:0]   r_len;
    logic [CHK_W-1:0]   r_sum;
    logic [LEN_W-1:0]   w_len_full;
    logic               w_start;
    logic               w_data_byte;
    logic               w_word_ready;
    logic [31:0]        w_word;

    assign w_len_full  = {in_data, r_len_lo};
    assign w_start     = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_data_byte = in_valid && (r_state == DATA);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_start),
        .byte_valid (w_data_byte),
        .byte_data  (in_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Status outputs are decoded from the state so they track it exactly,
    // including the immediate return to reset values on rst.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) w_next = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (w_len_full > LEN_W'(MEM_SIZE)) w_next = ERR;
                    else if (w_len_full == '0)         w_next = CHK;
                    else                               w_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_ready && (words_loaded == r_len - LEN_W'(1))) w_next = CHK;
            end
            CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next = (in_data == r_sum) ? DONE : ERR;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) w_next = LEN0;
            end
            ERR: begin
                error = 1'b1;
                if (start) w_next = LEN0;
            end
            default: w_next = IDLE;
        endcase
    end

    // The write register is separate from the assembly register, so the next
    // word's bytes can stream in while this one is being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_lo     <= '0;
            r_len        <= '0;
            r_sum        <= '0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
        end else begin
            mem_we <= w_word_ready;
            if (w_start) begin
                r_sum        <= '0;
                words_loaded <= '0;
                mem_addr     <= BASE_ADDR;
            end
            if (r_state == LEN0 && in_valid) r_len_lo <= in_data;
            if (r_state == LEN1 && in_valid) r_len    <= w_len_full;
            if (w_data_byte)                 r_sum    <= r_sum + in_data;
            if (w_word_ready) begin
                mem_wdata    <= w_word;
                mem_addr     <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
                words_loaded <= words_loaded + LEN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Expected memory writes are
//             queued as frames are driven and compared when mem_we fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    localparam logic [31:0] BASE = 32'h0000_0000;

    imem_loader #(.MEM_SIZE(17), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every mem_we pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [63:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_write addr=%h data=%h required=no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                assert ({mem_addr, mem_wdata} === e) else begin
                    miscompares++;
                    $error("FAIL mem_write observed=%h expected=%h", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sends LEN, payload (queueing the expected writes) and the given CHK byte.
    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [7:0] chkb, input int maxgap);
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(n);
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        send_byte(len[7:0]);
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        send_byte(len[15:8]);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int b = 0; b < 4; b++) begin
                if (b == 3) exp_q.push_back({BASE + 32'(4 * i), w});
                repeat ($urandom_range(0, maxgap)) @(negedge clk);
                send_byte(w[8*b +: 8]);
            end
        end
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        send_byte(chkb);
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                                input logic exp_hold, input int exp_words);
        @(negedge clk);
        chk({tag, "_done"},   {31'b0, done},     {31'b0, exp_done});
        chk({tag, "_error"},  {31'b0, error},    {31'b0, exp_err});
        chk({tag, "_hold"},   {31'b0, cpu_hold}, {31'b0, exp_hold});
        chk({tag, "_busy"},   {31'b0, busy},     32'd0);
        chk({tag, "_words"},  {16'b0, words_loaded}, 32'(exp_words));
        chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
        chk("rst_addr",     mem_addr,          BASE);
        chk("rst_wdata",    mem_wdata,         32'd0);
        chk("rst_hold",     {31'b0, cpu_hold}, 32'd1);
        chk("rst_busy",     {31'b0, busy},     32'd0);
        chk("rst_done",     {31'b0, done},     32'd0);
        chk("rst_error",    {31'b0, error},    32'd0);
        chk("rst_words",    {16'b0, words_loaded}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two-word load, good checksum.
        pulse_start();
        chk("start_busy", {31'b0, busy}, 32'd1);
        send_frame(2, 32'h0050_0093, 32'h00A0_0113, 8'h97, 0);
        check_status("two_word", 1'b1, 1'b0, 1'b0, 2);

        // Same image, bad checksum: writes still happen.
        pulse_start();
        send_frame(2, 32'h0050_0093, 32'h00A0_0113, 8'h98, 0);
        check_status("bad_chk", 1'b0, 1'b1, 1'b1, 2);

        // Oversize length.
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h00);
        check_status("oversize", 1'b0, 1'b1, 1'b1, 0);
        chk("oversize_in_ready", {31'b0, in_ready}, 32'd0);

        // Zero length, good then bad checksum.
        pulse_start();
        send_frame(0, 32'h0, 32'h0, 8'h00, 0);
        check_status("zero_ok", 1'b1, 1'b0, 1'b0, 0);
        pulse_start();
        send_frame(0, 32'h0, 32'h0, 8'h01, 0);
        check_status("zero_bad", 1'b0, 1'b1, 1'b1, 0);

        // One word with random valid gaps.
        pulse_start();
        send_frame(1, 32'h1234_5678, 32'h0, 8'h14, 5);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1);

        // Reset in the middle of a word: partial word is never written.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_hold",     {31'b0, cpu_hold}, 32'd1);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_busy",     {31'b0, busy},     32'd0);
        chk("midrst_words",    {16'b0, words_loaded}, 32'd0);
        chk("midrst_addr",     mem_addr,          BASE);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("midrst_no_we",    {31'b0, mem_we},   32'd0);
        pulse_start();
        send_frame(1, 32'h1234_5678, 32'h0, 8'h14, 5);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 1);

        // Reload from DONE: cpu_hold rises right after start.
        chk("reload_pre_hold", {31'b0, cpu_hold}, 32'd0);
        pulse_start();
        chk("reload_hold", {31'b0, cpu_hold}, 32'd1);
        chk("reload_done", {31'b0, done},     32'd0);
        send_frame(1, 32'hDEAD_BEEF, 32'h0, 8'h38, 0);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
